// File: rtl/reg_file_sb.sv
// Multi-port register file with an integrated busy scoreboard for RAW stall detection.
// Reads are combinational with optional same-cycle write bypass; writes and reservations land on the rising edge.
module reg_file_sb #(
  parameter  int WIDTH     = 32,
  parameter  int DEPTH     = 32,
  parameter  int NUM_READ  = 2,
  parameter  int NUM_WRITE = 2,
  parameter  int BYPASS    = 1,
  parameter  int ZERO_REG  = 1,
  localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_WRITE-1:0]       wr_en_i,
  input  logic [NUM_WRITE*AW-1:0]    wr_addr_i,
  input  logic [NUM_WRITE*WIDTH-1:0] wr_data_i,
  input  logic [NUM_READ*AW-1:0]     rd_addr_i,
  output logic [NUM_READ*WIDTH-1:0]  rd_data_o,
  output logic [NUM_READ-1:0]        rd_busy_o,
  input  logic                       rsv_en_i,
  input  logic [AW-1:0]              rsv_addr_i,
  input  logic                       flush_i,
  output logic [DEPTH-1:0]           busy_o
);

  // No backpressure: every write and reserve presented is taken in its cycle.
  logic [WIDTH-1:0]     mem [DEPTH];
  logic [DEPTH-1:0]     busy;
  logic [NUM_WRITE-1:0] wr_ok;
  logic [AW-1:0]        wa [NUM_WRITE];
  logic [WIDTH-1:0]     wd [NUM_WRITE];
  logic                 rsv_ok;

  function automatic logic addr_writable(input logic [AW-1:0] a);
    return (int'(a) < DEPTH) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  for (genvar p = 0; p < NUM_WRITE; p++) begin : g_wr
    assign wa[p]    = wr_addr_i[p*AW +: AW];
    assign wd[p]    = wr_data_i[p*WIDTH +: WIDTH];
    assign wr_ok[p] = wr_en_i[p] && !rst && addr_writable(wa[p]);
  end

  assign rsv_ok = rsv_en_i && !rst && addr_writable(rsv_addr_i);

  // Later ports are applied last, so the highest-index port wins a same-address conflict.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int p = 0; p < NUM_WRITE; p++) begin
        if (wr_ok[p]) mem[wa[p]] <= wd[p];
      end
    end
  end

  // Reservation is applied after writeback clears: the newly issued producer owns the register.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      busy <= '0;
    end else begin
      for (int p = 0; p < NUM_WRITE; p++) begin
        if (wr_ok[p]) busy[wa[p]] <= 1'b0;
      end
      if (rsv_ok) busy[rsv_addr_i] <= 1'b1;
    end
  end

  assign busy_o = busy;

  for (genvar r = 0; r < NUM_READ; r++) begin : g_rd
    logic [AW-1:0]    ra;
    logic [WIDTH-1:0] rd_d;
    logic             rd_b;

    assign ra = rd_addr_i[r*AW +: AW];

    always_comb begin
      rd_d = '0;
      rd_b = 1'b0;
      if (int'(ra) < DEPTH) begin
        rd_d = mem[ra];
        rd_b = busy[ra];
      end
      if (BYPASS != 0) begin
        for (int p = 0; p < NUM_WRITE; p++) begin
          if (wr_ok[p] && (wa[p] == ra)) begin
            rd_d = wd[p];
            rd_b = 1'b0;
          end
        end
      end
      if ((ZERO_REG != 0) && (ra == '0)) begin
        rd_d = '0;
        rd_b = 1'b0;
      end
    end

    assign rd_data_o[r*WIDTH +: WIDTH] = rd_d;
    assign rd_busy_o[r]                = rd_b;
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: one bypassing and one non-bypassing instance share stimulus;
// a reference model pushes expected outputs to a queue that is drained at the falling edge.
module tb_reg_file_sb;

  localparam int W  = 32;
  localparam int D  = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    wr_en;
  logic [2*AW-1:0] wr_addr;
  logic [2*W-1:0]  wr_data;
  logic [2*AW-1:0] rd_addr;
  logic          rsv_en;
  logic [AW-1:0] rsv_addr;
  logic          flush;

  logic [2*W-1:0] rd_data_a, rd_data_b;
  logic [1:0]     rd_busy_a, rd_busy_b;
  logic [D-1:0]   busy_a, busy_b;

  logic [W-1:0] mem_m [D];
  logic [D-1:0] busy_m;

  logic [W-1:0] exp_q [$];
  string        tag_q [$];
  int           checks = 0;
  int           errors = 0;

  always #5 clk = ~clk;

  reg_file_sb #(.WIDTH(W), .DEPTH(D), .NUM_READ(2), .NUM_WRITE(2), .BYPASS(1), .ZERO_REG(1)) dut_byp (
    .clk(clk), .rst(rst), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .rd_addr_i(rd_addr), .rd_data_o(rd_data_a), .rd_busy_o(rd_busy_a),
    .rsv_en_i(rsv_en), .rsv_addr_i(rsv_addr), .flush_i(flush), .busy_o(busy_a)
  );

  reg_file_sb #(.WIDTH(W), .DEPTH(D), .NUM_READ(2), .NUM_WRITE(2), .BYPASS(0), .ZERO_REG(1)) dut_nobyp (
    .clk(clk), .rst(rst), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .rd_addr_i(rd_addr), .rd_data_o(rd_data_b), .rd_busy_o(rd_busy_b),
    .rsv_en_i(rsv_en), .rsv_addr_i(rsv_addr), .flush_i(flush), .busy_o(busy_b)
  );

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_exp(input string tag, input logic [W-1:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic pop_check(input logic [W-1:0] got);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty got=%h exp=none", got);
    end else begin
      check(tag_q.pop_front(), got, exp_q.pop_front());
    end
  endtask

  function automatic logic write_hits(input int a);
    logic hit = 1'b0;
    for (int p = 0; p < 2; p++)
      if (!rst && wr_en[p] && int'(wr_addr[p*AW +: AW]) == a && a != 0) hit = 1'b1;
    return hit;
  endfunction

  function automatic logic [W-1:0] exp_rd(input int a, input bit byp);
    logic [W-1:0] v;
    if (a == 0) return '0;
    v = mem_m[a];
    if (byp && !rst)
      for (int p = 0; p < 2; p++)
        if (wr_en[p] && int'(wr_addr[p*AW +: AW]) == a) v = wr_data[p*W +: W];
    return v;
  endfunction

  function automatic logic exp_rb(input int a, input bit byp);
    if (a == 0) return 1'b0;
    if (byp && write_hits(a)) return 1'b0;
    return busy_m[a];
  endfunction

  task automatic model_edge();
    int a;
    if (rst) begin
      for (int i = 0; i < D; i++) mem_m[i] = '0;
      busy_m = '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        a = int'(wr_addr[p*AW +: AW]);
        if (wr_en[p] && a != 0) mem_m[a] = wr_data[p*W +: W];
      end
      if (flush) busy_m = '0;
      else begin
        for (int p = 0; p < 2; p++) begin
          a = int'(wr_addr[p*AW +: AW]);
          if (wr_en[p] && a != 0) busy_m[a] = 1'b0;
        end
        if (rsv_en && rsv_addr != '0) busy_m[rsv_addr] = 1'b1;
      end
    end
  endtask

  // Inputs are stable from posedge+1; expectations pushed now, outputs compared at negedge.
  task automatic step();
    int a;
    for (int r = 0; r < 2; r++) begin
      a = int'(rd_addr[r*AW +: AW]);
      push_exp($sformatf("rd_data%0d_byp x%0d", r, a), exp_rd(a, 1'b1));
      push_exp($sformatf("rd_data%0d_nobyp x%0d", r, a), exp_rd(a, 1'b0));
      push_exp($sformatf("rd_busy%0d_byp x%0d", r, a), {31'b0, exp_rb(a, 1'b1)});
      push_exp($sformatf("rd_busy%0d_nobyp x%0d", r, a), {31'b0, exp_rb(a, 1'b0)});
    end
    push_exp("busy_o_byp", busy_m);
    push_exp("busy_o_nobyp", busy_m);
    @(negedge clk);
    for (int r = 0; r < 2; r++) begin
      pop_check(rd_data_a[r*W +: W]);
      pop_check(rd_data_b[r*W +: W]);
      pop_check({31'b0, rd_busy_a[r]});
      pop_check({31'b0, rd_busy_b[r]});
    end
    pop_check(busy_a);
    pop_check(busy_b);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    wr_en = '0; rsv_en = 1'b0; flush = 1'b0; rst = 1'b0;
  endtask

  task automatic set_wr(input int p, input int addr, input logic [W-1:0] data);
    wr_en[p] = 1'b1;
    wr_addr[p*AW +: AW] = AW'(addr);
    wr_data[p*W +: W] = data;
  endtask

  task automatic set_rd(input int a0, input int a1);
    rd_addr = {AW'(a1), AW'(a0)};
  endtask

  initial begin
    rst = 1'b1; wr_en = '0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    rsv_en = 1'b0; rsv_addr = '0; flush = 1'b0;
    for (int i = 0; i < D; i++) mem_m[i] = '0;
    busy_m = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < D / 2; i++) begin
      set_rd(2 * i, 2 * i + 1);
      step();
    end

    idle(); set_wr(0, 5, 32'hDEADBEEF); set_rd(5, 5); step();
    idle(); step();

    idle(); set_wr(0, 7, 32'h1111); set_wr(1, 7, 32'h2222); set_rd(7, 5); step();
    idle(); step();

    idle(); set_wr(0, 0, 32'hFFFF); set_rd(0, 7); step();
    idle(); step();

    idle(); rsv_en = 1'b1; rsv_addr = 5'd3; set_rd(3, 0); step();
    idle(); step();
    idle(); set_wr(1, 3, 32'h33); step();
    idle(); step();

    idle(); rsv_en = 1'b1; rsv_addr = 5'd9; set_wr(0, 9, 32'h9999); set_rd(9, 3); step();
    idle(); step();

    idle(); rsv_en = 1'b1; rsv_addr = 5'd12; set_rd(12, 10); step();
    idle(); flush = 1'b1; rsv_en = 1'b1; rsv_addr = 5'd10; step();
    idle(); step();

    idle(); rsv_en = 1'b1; rsv_addr = 5'd4; set_wr(0, 4, 32'hAB); set_rd(4, 9); rst = 1'b1; step();
    idle(); step();

    for (int i = 0; i < 300; i++) begin
      idle();
      wr_en = 2'($urandom_range(0, 3));
      wr_addr = {AW'($urandom_range(0, D - 1)), AW'($urandom_range(0, D - 1))};
      wr_data = {$urandom, $urandom};
      rsv_en = 1'($urandom_range(0, 1));
      rsv_addr = AW'($urandom_range(0, D - 1));
      flush = ($urandom_range(0, 15) == 0);
      rst = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 1) == 1) rd_addr = {wr_addr[AW +: AW], wr_addr[0 +: AW]};
      else set_rd($urandom_range(0, D - 1), $urandom_range(0, D - 1));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
